// File: rtl/dec_entry_decoder.sv
// dec_entry_decoder: decimal key entry to an 8-bit immediate; define DEC_ENTRY_DEBOUNCE_EN for per-key debounce
module dec_entry_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_DIGITS = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] digitIn,
  input  logic       keyPush,
  input  logic       keyEnter,
  input  logic       keyClear,
  output logic [7:0] immValue,
  output logic       immValid,
  output logic       overflow,
  output logic       badDigit,
  output logic [1:0] digitCount,
  output logic [9:0] entryValue
);
`ifdef DEC_ENTRY_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  typedef enum logic {IDLE, ENTRY} state_t;
  state_t state, state_n;
  logic [2:0] key, s1, s2, lvl, lvl_q, armed, ev;
  logic clr, ent, psh, accept, commit, reject;
  logic [9:0] acc_n;
  logic [1:0] cnt_n;
  logic [7:0] imm_n;
  logic ovf_n, valid_n, bad_n;
  assign key = {keyClear, keyEnter, keyPush};
  // armed stays low until a key is seen released, so a key held through reset yields no event
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1 <= '0;
      s2 <= '0;
      lvl_q <= '0;
      armed <= '0;
      ev <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      lvl_q <= lvl;
      armed <= armed | (~key & ~lvl);
      ev <= lvl & ~lvl_q & armed;
    end
  end
  if (DB_EN && DEBOUNCE_CYCLES > 1) begin : g_db
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    for (genvar k = 0; k < 3; k++) begin : g_key
      logic [CW-1:0] cnt;
      logic lv;
      always_ff @(posedge clock) begin
        if (!resetn) begin
          cnt <= '0;
          lv <= 1'b0;
        end else if (s2[k] == lv) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt <= '0;
          lv <= s2[k];
        end else cnt <= cnt + 1'b1;
      end
      assign lvl[k] = lv;
    end
  end else begin : g_nodb
    assign lvl = s2;
  end
  assign clr = ev[2];
  assign ent = ev[1] & ~ev[2];
  assign psh = ev[0] & ~ev[1] & ~ev[2];
  assign accept = psh && digitIn <= 4'd9 && digitCount < 2'(MAX_DIGITS);
  assign commit = ent && state == ENTRY && entryValue <= 10'd255;
  assign reject = ent && state == ENTRY && entryValue > 10'd255;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      entryValue <= '0;
      digitCount <= '0;
      immValue <= '0;
      immValid <= 1'b0;
      badDigit <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      entryValue <= acc_n;
      digitCount <= cnt_n;
      immValue <= imm_n;
      immValid <= valid_n;
      badDigit <= bad_n;
      overflow <= ovf_n;
    end
  end
  always_comb begin
    state_n = (clr || commit) ? IDLE : accept ? ENTRY : state;
  end
  always_comb begin
    acc_n = (clr || commit) ? 10'd0 :
            accept ? (entryValue << 3) + (entryValue << 1) + {6'd0, digitIn} : entryValue;
    cnt_n = (clr || commit) ? 2'd0 : accept ? digitCount + 2'd1 : digitCount;
    imm_n = commit ? entryValue[7:0] : immValue;
    ovf_n = (clr || commit) ? 1'b0 : reject ? 1'b1 : overflow;
    valid_n = commit;
    bad_n = psh && !accept;
  end
endmodule

// File: tb/tb_dec_entry_decoder.sv
// tb_dec_entry_decoder: directed plus random key entry checked against a digit-queue model
module tb_dec_entry_decoder;
  localparam int D = 16;
`ifdef DEC_ENTRY_DEBOUNCE_EN
  localparam int LAT = 3 + D;
`else
  localparam int LAT = 3;
`endif
  localparam int H = LAT + 3;
  localparam int T = 2 * LAT + 6;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] digitIn = 4'd0;
  logic keyPush = 1'b0, keyEnter = 1'b0, keyClear = 1'b0;
  logic [7:0] immValue;
  logic immValid, overflow, badDigit;
  logic [1:0] digitCount;
  logic [9:0] entryValue;
  int n_checks = 0;
  int n_errors = 0;
  int q[$];
  int imm_m = 0;
  int ovf_m = 0;
  always #5 clock = ~clock;
  dec_entry_decoder #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(3)) dut (
    .clock(clock), .resetn(resetn), .digitIn(digitIn), .keyPush(keyPush),
    .keyEnter(keyEnter), .keyClear(keyClear), .immValue(immValue), .immValid(immValid),
    .overflow(overflow), .badDigit(badDigit), .digitCount(digitCount), .entryValue(entryValue)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int model_value();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction
  task automatic check_state(input string pfx);
    check({pfx, "_entry"}, int'(entryValue), model_value());
    check({pfx, "_count"}, int'(digitCount), q.size());
    check({pfx, "_imm"}, int'(immValue), imm_m);
    check({pfx, "_ovf"}, int'(overflow), ovf_m);
  endtask
  // k = {clear, enter, push}; called and returns just after a negedge
  task automatic press(input logic [2:0] k, input int d);
    int old_acc = model_value();
    int old_cnt = q.size();
    int old_imm = imm_m;
    int old_ovf = ovf_m;
    int ev = 0, eb = 0, nv = 0, nb = 0, both = 0;
    if (k[2]) begin
      q.delete();
      ovf_m = 0;
    end else if (k[1]) begin
      if (q.size() > 0) begin
        if (model_value() <= 255) begin
          imm_m = model_value();
          ovf_m = 0;
          ev = 1;
          q.delete();
        end else ovf_m = 1;
      end
    end else if (k[0]) begin
      if (d <= 9 && q.size() < 3) q.push_back(d);
      else eb = 1;
    end
    digitIn = 4'(d);
    {keyClear, keyEnter, keyPush} = k;
    for (int i = 0; i < T; i++) begin
      @(posedge clock);
      @(negedge clock);
      nv += int'(immValid);
      nb += int'(badDigit);
      both += int'(immValid & badDigit);
      if (i == LAT - 1) begin
        check("pre_entry", int'(entryValue), old_acc);
        check("pre_count", int'(digitCount), old_cnt);
        check("pre_imm", int'(immValue), old_imm);
        check("pre_ovf", int'(overflow), old_ovf);
      end
      if (i == LAT) begin
        check("valid_at_lat", int'(immValid), ev);
        check("bad_at_lat", int'(badDigit), eb);
        check_state("lat");
      end
      if (i == H - 1) {keyClear, keyEnter, keyPush} = 3'b000;
    end
    check("valid_pulses", nv, ev);
    check("bad_pulses", nb, eb);
    check("both_strobes", both, 0);
    check_state("final");
  endtask
  task automatic do_reset(input logic hold);
    resetn = 1'b0;
    keyPush = hold;
    keyEnter = 1'b0;
    keyClear = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rst_imm", int'(immValue), 0);
    check("rst_valid", int'(immValid), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_bad", int'(badDigit), 0);
    check("rst_count", int'(digitCount), 0);
    check("rst_entry", int'(entryValue), 0);
    resetn = 1'b1;
    q.delete();
    imm_m = 0;
    ovf_m = 0;
  endtask
  task automatic idle_watch(input int n, input string tag);
    int strobes = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      strobes += int'(immValid) + int'(badDigit);
    end
    check({tag, "_strobes"}, strobes, 0);
    check_state(tag);
  endtask
  initial begin
    @(negedge clock);
    @(negedge clock);
    do_reset(1'b0);
    repeat (2) @(negedge clock);
    press(3'b001, 1); press(3'b001, 9); press(3'b001, 2); press(3'b010, 0);
    press(3'b001, 2); press(3'b001, 5); press(3'b001, 6); press(3'b010, 0);
    press(3'b100, 0);
    press(3'b001, 12);
    press(3'b001, 7); press(3'b001, 7); press(3'b001, 7); press(3'b001, 3);
    press(3'b100, 0);
    press(3'b001, 4); press(3'b001, 5); press(3'b110, 0); press(3'b010, 0);
    press(3'b001, 8); press(3'b001, 3);
    digitIn = 4'd2;
    do_reset(1'b1);
    idle_watch(30, "held");
    keyPush = 1'b0;
    idle_watch(LAT + 6, "released");
    press(3'b001, 4); press(3'b010, 0);
`ifdef DEC_ENTRY_DEBOUNCE_EN
    digitIn = 4'd5;
    keyPush = 1'b1;
    repeat (10) @(negedge clock);
    keyPush = 1'b0;
    idle_watch(30, "glitch");
    press(3'b001, 5); press(3'b100, 0);
`endif
    for (int n = 0; n < 80; n++) begin
      int r = $urandom_range(0, 99);
      logic [2:0] k = r < 65 ? 3'b001 : r < 82 ? 3'b010 : r < 90 ? 3'b100 : 3'($urandom_range(1, 7));
      int d = $urandom_range(0, 99) < 85 ? $urandom_range(0, 9) : $urandom_range(10, 15);
      press(k, d);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
